// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_pkg
//  Description : Shared definitions for the nibble-serial adder/subtractor:
//                controller state encoding and the nibble width.
//  Contents    : NIB     - width of the shared adder slice (4 bits)
//                state_t - IDLE / RUN / DONE controller states
//  Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : nibble_serial_adder_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_4bit
//  Description : Purely combinational 4-bit ripple-carry adder. This is the
//                only arithmetic element of the nibble-serial adder.
//  Ports       : a_i  [3:0] - addend A
//                b_i  [3:0] - addend B
//                ci_i       - carry in
//                s_o  [3:0] - sum
//                co_o       - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB-1:0] a_i,
    input  logic [NIB-1:0] b_i,
    input  logic           ci_i,
    output logic [NIB-1:0] s_o,
    output logic           co_o
);

    logic [NIB:0] w_c;

    assign w_c[0] = ci_i;

    for (genvar i = 0; i < NIB; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
        assign w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o = w_c[NIB];

endmodule : adder_4bit
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : Multi-cycle WIDTH-bit adder/subtractor that streams both
//                operands through a single 4-bit adder, one nibble per clock,
//                LSB nibble first, carrying between steps.
//  Ports       : clk        - rising-edge clock
//                rst_n      - asynchronous active-low reset
//                start_i    - request, sampled only when not busy
//                a_i, b_i   - operands, captured on the accepting edge
//                cin_i      - carry in for add (ignored for subtract)
//                sub_i      - 0: A+B+cin, 1: A-B
//                busy_o     - high while the operation is in flight
//                done_o     - one-cycle pulse, result valid
//                sum_o      - result, held until the next accepted start
//                cout_o     - final carry (subtract: 1 = no borrow)
//                ovf_o      - two's-complement overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int N  = WIDTH / NIB;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_LAST_STEP = CW'(N - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic [NIB-1:0]   w_nib;
    logic             w_nib_co;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [WIDTH-1:0] w_sum_shift;
    logic             w_last;

    // ------------------------------------------------------------------
    // Shared nibble adder: always fed from the low nibble of the operand
    // shift registers and the inter-step carry.
    // ------------------------------------------------------------------
    adder_4bit u_adder (
        .a_i  (a_q[NIB-1:0]),
        .b_i  (b_q[NIB-1:0]),
        .ci_i (carry_q),
        .s_o  (w_nib),
        .co_o (w_nib_co)
    );

    // Subtraction is A + ~B + 1; inversion happens once at capture time.
    assign w_b_eff = sub_i ? ~b_i : b_i;
    assign w_last  = (cnt_q == c_LAST_STEP);

    // A single-nibble operand has nothing above the low nibble to shift in,
    // so the shift paths are split to keep every slice in range.
    if (N > 1) begin : g_multi
        assign w_a_shift   = {{NIB{1'b0}}, a_q[WIDTH-1:NIB]};
        assign w_b_shift   = {{NIB{1'b0}}, b_q[WIDTH-1:NIB]};
        assign w_sum_shift = {w_nib, sum_q[WIDTH-1:NIB]};
    end else begin : g_single
        assign w_a_shift   = '0;
        assign w_b_shift   = '0;
        assign w_sum_shift = w_nib;
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_d      = a_i;
                    b_d      = w_b_eff;
                    carry_d  = sub_i ? 1'b1 : cin_i;
                    cnt_d    = '0;
                    sign_a_d = a_i[WIDTH-1];
                    sign_b_d = w_b_eff[WIDTH-1];
                    state_d  = RUN;
                end else if (state_q == DONE) begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                sum_d   = w_sum_shift;
                a_d     = w_a_shift;
                b_d     = w_b_shift;
                carry_d = w_nib_co;
                if (w_last) begin
                    // Counter is left at its final value so it never wraps.
                    cout_d  = w_nib_co;
                    ovf_d   = (sign_a_q == sign_b_q) && (w_nib[NIB-1] != sign_a_q);
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Self-checking bench for nibble_serial_adder. Drives a
//                WIDTH=16 and a WIDTH=4 instance; expected results are
//                queued when a request is driven and compared when done
//                pulses, along with the done latency and pulse width.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t q16[$];
    exp_t q4[$];
    exp_t e16, e4;
    logic prev_done16 = 1'b0;
    logic prev_done4  = 1'b0;

    logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic        start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start16),
        .a_i     (a16),
        .b_i     (b16),
        .cin_i   (cin16),
        .sub_i   (sub16),
        .busy_o  (busy16),
        .done_o  (done16),
        .sum_o   (sum16),
        .cout_o  (cout16),
        .ovf_o   (ovf16)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start4),
        .a_i     (a4),
        .b_i     (b4),
        .cin_i   (cin4),
        .sub_i   (sub4),
        .busy_o  (busy4),
        .done_o  (done4),
        .sum_o   (sum4),
        .cout_o  (cout4),
        .ovf_o   (ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // Whole-word reference: A + (sub ? ~B : B) + (sub ? 1 : cin).
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [32:0] mask, beff, full;
        exp_t r;
        mask  = (33'd1 << w) - 33'd1;
        beff  = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        full  = ({1'b0, a} & mask) + beff + (sub ? 33'd1 : {32'd0, cin});
        r.sum  = full[31:0] & mask[31:0];
        r.cout = full[w];
        r.ovf  = (a[w-1] == beff[w-1]) && (r.sum[w-1] != a[w-1]);
        r.acc  = 0;
        return r;
    endfunction

    // Called #1 after a rising edge; the request is taken at the next edge.
    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic push);
        exp_t e;
        a16 = a; b16 = b; cin16 = cin; sub16 = sub; start16 = 1'b1;
        if (push) begin
            e = model(16, {16'd0, a}, {16'd0, b}, cin, sub);
            e.acc = cyc + 1;
            q16.push_back(e);
        end
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic sub);
        exp_t e;
        a4 = a; b4 = b; cin4 = cin; sub4 = sub; start4 = 1'b1;
        e = model(4, {28'd0, a}, {28'd0, b}, cin, sub);
        e.acc = cyc + 1;
        q4.push_back(e);
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic drain16();
        for (int i = 0; i < 40; i++) begin
            if (q16.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain16_timeout", 32'(q16.size()), 32'd0);
    endtask

    task automatic drain4();
        for (int i = 0; i < 40; i++) begin
            if (q4.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain4_timeout", 32'(q4.size()), 32'd0);
    endtask

    task automatic wait_done16();
        for (int i = 0; i < 40; i++) begin
            if (done16) break;
            @(posedge clk); #1;
        end
        chk("wait_done16_timeout", {31'd0, done16}, 32'd1);
    endtask

    // Scoreboard monitors: compare on the falling edge while done is high.
    always @(negedge clk) begin
        if (done16) begin
            chk("done16_pulse_width", {31'd0, prev_done16}, 32'd0);
            if (q16.size() == 0) begin
                chk("done16_unexpected", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                chk("sum16",     32'(sum16),  e16.sum);
                chk("cout16",    {31'd0, cout16}, {31'd0, e16.cout});
                chk("ovf16",     {31'd0, ovf16},  {31'd0, e16.ovf});
                chk("latency16", 32'(cyc - e16.acc), 32'd4);
            end
        end
        prev_done16 <= done16;
    end

    always @(negedge clk) begin
        if (done4) begin
            chk("done4_pulse_width", {31'd0, prev_done4}, 32'd0);
            if (q4.size() == 0) begin
                chk("done4_unexpected", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                chk("sum4",     32'(sum4),  e4.sum);
                chk("cout4",    {31'd0, cout4}, {31'd0, e4.cout});
                chk("ovf4",     {31'd0, ovf4},  {31'd0, e4.ovf});
                chk("latency4", 32'(cyc - e4.acc), 32'd1);
            end
        end
        prev_done4 <= done4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy16", {31'd0, busy16}, 32'd0);
        chk("rst_done16", {31'd0, done16}, 32'd0);
        chk("rst_sum16",  32'(sum16), 32'd0);
        chk("rst_cout16", {31'd0, cout16}, 32'd0);
        chk("rst_ovf16",  {31'd0, ovf16}, 32'd0);
        chk("rst_busy4",  {31'd0, busy4}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add; busy from the accepting edge
        op16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
        chk("busy16_after_accept", {31'd0, busy16}, 32'd1);
        chk("done16_after_accept", {31'd0, done16}, 32'd0);
        drain16();

        // Carry out and signed overflow on add
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain16();
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain16();

        // Subtract: cin ignored, borrow and overflow cases
        op16(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        drain16();
        op16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        drain16();

        // Start during RUN must be ignored
        op16(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        op16(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
        drain16();

        // Start in the DONE cycle is accepted back-to-back
        op16(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1);
        wait_done16();
        op16(16'h0F00, 16'h0100, 1'b0, 1'b1, 1'b1);
        chk("busy16_b2b", {31'd0, busy16}, 32'd1);
        drain16();

        // Asynchronous reset mid-RUN, after two nibble steps
        op16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy16", {31'd0, busy16}, 32'd0);
        chk("abort_done16", {31'd0, done16}, 32'd0);
        chk("abort_sum16",  32'(sum16), 32'd0);
        chk("abort_cout16", {31'd0, cout16}, 32'd0);
        chk("abort_ovf16",  {31'd0, ovf16}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        op16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1);
        drain16();

        // Single-nibble instance
        op4(4'hF, 4'h1, 1'b1, 1'b0);
        drain4();
        op4(4'h3, 4'h5, 1'b0, 1'b1);
        drain4();
        op4(4'h7, 4'h1, 1'b0, 1'b0);
        drain4();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nibble_serial_adder
`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder/subtractor built around one shared 4-bit ripple-carry adder. The block latches two WIDTH-bit operands on a start strobe, feeds them through the 4-bit adder one nibble per clock (LSB nibble first), and carries the nibble carry between cycles. It returns the sum, carry-out and signed overflow with a one-cycle done pulse. It is the sequencing controller that lets the 4-bit full adder datapath serve any multiple-of-4 operand width.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 is the number of nibble steps.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  0 = A+B+cin, 1 = A−B (B inverted, carry-in forced to 1).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; valid while done=1 and held until the next accepted start.
- cout  out  1  final carry (for sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE or DONE, start=1:
  - capture a into A shift register.
  - capture (sub ? ~b : b) into B shift register.
  - carry register ← sub ? 1 : cin.
  - step counter ← 0.
  - store the operand sign bits a[WIDTH-1] and b_eff[WIDTH-1].
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE.
- RUN, each cycle:
  - the 4-bit adder adds A[3:0], B[3:0] and the carry register.
  - the nibble result shifts into sum from the top (sum ← {nib, sum[WIDTH-1:4]}).
  - A and B shift right by 4.
  - carry register ← nibble carry-out.
  - counter increments.
- RUN, on the step where counter = N−1:
  - cout ← nibble carry-out.
  - ovf ← (signA == signB_eff) && (nib[3] != signA).
  - go to DONE.
- done = (state == DONE). busy = (state == RUN).
- start while busy=1 is ignored; the in-flight operation is unaffected.
- sum is not meaningful while busy=1.
- Counter is $clog2(N) bits (1 bit minimum) and never wraps in use. It reloads on every accepted start.

## Timing
- Reset (async assert, any state including mid-RUN): state=IDLE; busy, done, cout, ovf, sum, shift registers, carry and counter all 0. Takes effect immediately, without waiting for a clock edge.
- Reset release: first start can be accepted on the first rising edge with rst_n=1.
- Start accepted at edge E0:
  - busy=1 from E0.
  - nibble k is computed in the cycle before edge E(k+1).
  - done=1 and busy=0 between edges EN and EN+1.
  - Latency from the accepting edge to done is N cycles. WIDTH=16 gives done after E4.
- Back-to-back: a start in the DONE cycle is accepted at EN+1. Throughput is one result per N+1 cycles.
- N=1 (WIDTH=4): RUN lasts one cycle, so done is visible after E1.

## Structure
- Shared package: state enum (IDLE/RUN/DONE) and the nibble width constant NIB=4.
- One sub-module, adder_4bit: purely combinational a[3:0], b[3:0], ci → s[3:0], co.
  - Instantiated exactly once; this module is the only path through which arithmetic is done.
- All sequencing, shift registers and flag logic stay in nibble_serial_adder.

## Test plan
- WIDTH=16, add, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0; done rises exactly 4 edges after the accepting edge and lasts 1 cycle.
- Add, a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Sub, a=0x0005, b=0x0007, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Then sub, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
- Start with a=0x0001, b=0x0001, then pulse start with a=0xAAAA, b=0x5555 during RUN → the second request is ignored; sum=0x0002. Start asserted during the DONE cycle → accepted, and its done follows 4 edges later.
- Assert rst_n=0 mid-RUN (after 2 steps) → busy, done, sum, cout and ovf go to 0 immediately, with no done pulse. After release, a=0x0F0F+b=0x00F1 completes correctly: 0x1000, cout=0.
- WIDTH=4 instance, a=0xF, b=0x1, cin=1 → sum=0x1, cout=1, ovf=0; done visible 1 edge after acceptance.
